semaforo_monitor: RTL and testbench

- Receiving end of the traffic-light controller's LA/LB/on outputs.
- Decodes the 2-bit light codes into per-lamp drives (red/yellow/green) for directions A and B.
- Independently checks every sample for unsafe conditions; on any violation it latches a fault, overrides both directions to flashing yellow, and holds until cleared.
- Sits between the light state machine and the physical lamp drivers.

---
 rtl/semaforo_pkg.sv | 39 +++
 rtl/semaforo_lamp_dir.sv | 48 ++++
 rtl/semaforo_monitor.sv | 152 +++++++++++++++
 tb/tb_semaforo_monitor.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared types for the traffic-light monitor: light codes, monitor states,
// fault codes and lamp one-hot drives.
package semaforo_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    RED     = 2'b10,
    INVALID = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE       = 2'b00,
    FC_CONFLICT   = 2'b01,
    FC_INVALID    = 2'b10,
    FC_TRANSITION = 2'b11
  } fault_code_t;

  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  function automatic logic [2:0] decode_lamp(input light_t c);
    case (c)
      GREEN:   return LAMP_GREEN;
      YELLOW:  return LAMP_YELLOW;
      RED:     return LAMP_RED;
      default: return LAMP_OFF;
    endcase
  endfunction

endpackage

// File: rtl/semaforo_lamp_dir.sv
// One direction of the monitor: consecutive-yellow counter, legal-transition
// check against the previous sample, and code-to-lamp decode.
module semaforo_lamp_dir
  import semaforo_pkg::*;
#(
  parameter int unsigned MIN_YELLOW = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  light_t     code,
  input  light_t     prev,
  input  logic       hist_valid,
  input  logic       sample,
  output logic       legal,
  output logic [2:0] lamp
);

  localparam int unsigned YW = $clog2(MIN_YELLOW + 1);

  logic [YW-1:0] ycnt;

  // Counts yellow samples accepted in RUN; any other edge clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ycnt <= '0;
    end else if (sample && code == YELLOW) begin
      if (ycnt != YW'(MIN_YELLOW))
        ycnt <= ycnt + 1'b1;
    end else begin
      ycnt <= '0;
    end
  end

  always_comb begin
    legal = 1'b1;
    if (hist_valid && code != prev) begin
      case (prev)
        GREEN:   legal = (code == YELLOW);
        RED:     legal = (code == GREEN);
        YELLOW:  legal = (code == RED) && (ycnt >= YW'(MIN_YELLOW));
        default: legal = 1'b0;
      endcase
    end
  end

  assign lamp = decode_lamp(code);

endmodule

// File: rtl/semaforo_monitor.sv
// Safety monitor between the light FSM and the lamp drivers. Optional fault
// statistics counter enabled by defining SEMAFORO_MON_STATS_EN.
module semaforo_monitor
  import semaforo_pkg::*;
#(
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned BLINK_HALF = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] LA,
  input  logic [1:0] LB,
  input  logic       on,
  input  logic       clr,
  output logic [2:0] lamp_a,
  output logic [2:0] lamp_b,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] fault_cnt
);

  localparam int unsigned BW = $clog2(BLINK_HALF + 1);

  light_t      r_la, r_lb, p_la, p_lb;
  logic        r_on, r_clr;
  state_t      state;
  logic        hist_valid;
  logic [BW-1:0] blink_cnt;

  logic        sample, legal_a, legal_b, violation, clear_ok;
  logic [2:0]  dec_a, dec_b;
  fault_code_t viol_code;

  semaforo_lamp_dir #(.MIN_YELLOW(MIN_YELLOW)) u_dir_a (
    .clk        (clk),
    .rst        (rst),
    .code       (r_la),
    .prev       (p_la),
    .hist_valid (hist_valid),
    .sample     (sample),
    .legal      (legal_a),
    .lamp       (dec_a)
  );

  semaforo_lamp_dir #(.MIN_YELLOW(MIN_YELLOW)) u_dir_b (
    .clk        (clk),
    .rst        (rst),
    .code       (r_lb),
    .prev       (p_lb),
    .hist_valid (hist_valid),
    .sample     (sample),
    .legal      (legal_b),
    .lamp       (dec_b)
  );

  // The OFF->RUN edge already processes its sample; history is still invalid
  // there, so only the invalid/conflict checks can fire.
  always_comb begin
    sample    = r_on && (state != FAULT);
    viol_code = FC_NONE;
    if (r_la == INVALID || r_lb == INVALID)
      viol_code = FC_INVALID;
    else if (r_la != RED && r_lb != RED)
      viol_code = FC_CONFLICT;
    else if (!legal_a || !legal_b)
      viol_code = FC_TRANSITION;
    violation = sample && (viol_code != FC_NONE);
    clear_ok  = (state == FAULT) && r_clr && (r_la == RED) && (r_lb == RED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_la       <= GREEN;
      r_lb       <= GREEN;
      r_on       <= 1'b0;
      r_clr      <= 1'b0;
      p_la       <= GREEN;
      p_lb       <= GREEN;
      state      <= OFF;
      hist_valid <= 1'b0;
      blink_cnt  <= '0;
      lamp_a     <= LAMP_OFF;
      lamp_b     <= LAMP_OFF;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      r_la  <= light_t'(LA);
      r_lb  <= light_t'(LB);
      r_on  <= on;
      r_clr <= clr;
      p_la  <= r_la;
      p_lb  <= r_lb;
      case (state)
        OFF, RUN: begin
          if (!r_on) begin
            state      <= OFF;
            hist_valid <= 1'b0;
            lamp_a     <= LAMP_OFF;
            lamp_b     <= LAMP_OFF;
          end else if (violation) begin
            state      <= FAULT;
            hist_valid <= 1'b0;
            fault      <= 1'b1;
            fault_code <= viol_code;
            blink_cnt  <= '0;
            lamp_a     <= LAMP_YELLOW;
            lamp_b     <= LAMP_YELLOW;
          end else begin
            state      <= RUN;
            hist_valid <= 1'b1;
            lamp_a     <= dec_a;
            lamp_b     <= dec_b;
          end
        end
        FAULT: begin
          hist_valid <= 1'b0;
          if (clear_ok) begin
            state      <= r_on ? RUN : OFF;
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            lamp_a     <= r_on ? dec_a : LAMP_OFF;
            lamp_b     <= r_on ? dec_b : LAMP_OFF;
          end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            blink_cnt <= '0;
            lamp_a    <= lamp_a ^ LAMP_YELLOW;
            lamp_b    <= lamp_b ^ LAMP_YELLOW;
          end else begin
            blink_cnt <= blink_cnt + 1'b1;
          end
        end
        default: begin
          state      <= OFF;
          hist_valid <= 1'b0;
          lamp_a     <= LAMP_OFF;
          lamp_b     <= LAMP_OFF;
        end
      endcase
    end
  end

`ifdef SEMAFORO_MON_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      fault_cnt <= '0;
    else if (violation && fault_cnt != '1)
      fault_cnt <= fault_cnt + 8'd1;
  end
`else
  assign fault_cnt = '0;
`endif

endmodule

// File: tb/tb_semaforo_monitor.sv
// Self-checking bench for semaforo_monitor against a queue-based reference
// model; fault_cnt expectations follow SEMAFORO_MON_STATS_EN.
module tb_semaforo_monitor;

  localparam int unsigned MIN_YELLOW = 2;
  localparam int unsigned BLINK_HALF = 5;
  localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10, X = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1, on = 1'b0, clr = 1'b0;
  logic [1:0] LA = G, LB = G;
  logic [2:0] lamp_a, lamp_b;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] fault_cnt;

  int errors = 0;
  int checks = 0;

  semaforo_monitor #(.MIN_YELLOW(MIN_YELLOW), .BLINK_HALF(BLINK_HALF)) dut (
    .clk        (clk),
    .rst        (rst),
    .LA         (LA),
    .LB         (LB),
    .on         (on),
    .clr        (clr),
    .lamp_a     (lamp_a),
    .lamp_b     (lamp_b),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_cnt  (fault_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: accepted RUN samples kept as per-direction histories.
  typedef enum int {M_OFF, M_RUN, M_FAULT} mstate_t;
  mstate_t    mst = M_OFF;
  int         qa[$], qb[$];
  int         blink_n = 0;
  int         ecnt = 0;
  logic [2:0] ea = '0, eb = '0;
  logic       ef = 1'b0;
  logic [1:0] ec = '0;
  logic [1:0] pla = G, plb = G;
  logic       pon = 1'b0, pclr = 1'b0;

  function automatic logic [2:0] lamp_of(input logic [1:0] c);
    return (c == G) ? 3'b001 : (c == Y) ? 3'b010 : (c == R) ? 3'b100 : 3'b000;
  endfunction

  function automatic int yrun(input int q[$]);
    int n = 0;
    int i = q.size() - 1;
    while (i >= 0 && q[i] == int'(Y)) begin
      n++;
      i--;
    end
    return n;
  endfunction

  function automatic bit legal(input int prev, input int cur, input int yr);
    if (prev == cur) return 1'b1;
    if (prev == int'(G) && cur == int'(Y)) return 1'b1;
    if (prev == int'(R) && cur == int'(G)) return 1'b1;
    if (prev == int'(Y) && cur == int'(R) && yr >= int'(MIN_YELLOW)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [16:0] obs();
    return {lamp_a, lamp_b, fault, fault_code, fault_cnt};
  endfunction

  function automatic logic [16:0] exp_out();
    return {ea, eb, ef, ec, 8'(ecnt)};
  endfunction

  task automatic model_process();
    int code;
    if (mst == M_FAULT) begin
      if (pclr && pla == R && plb == R) begin
        ef = 1'b0; ec = '0;
        qa.delete(); qb.delete();
        if (pon) begin
          mst = M_RUN; ea = lamp_of(pla); eb = lamp_of(plb);
        end else begin
          mst = M_OFF; ea = '0; eb = '0;
        end
      end else begin
        blink_n++;
        ea = (((blink_n / BLINK_HALF) % 2) == 0) ? 3'b010 : 3'b000;
        eb = ea;
      end
    end else if (!pon) begin
      mst = M_OFF; qa.delete(); qb.delete(); ea = '0; eb = '0;
    end else begin
      code = 0;
      if (pla == X || plb == X) code = 2;
      else if (pla != R && plb != R) code = 1;
      else if (qa.size() > 0 &&
               (!legal(qa[$], int'(pla), yrun(qa)) || !legal(qb[$], int'(plb), yrun(qb))))
        code = 3;
      if (code != 0) begin
        mst = M_FAULT; ef = 1'b1; ec = 2'(code); blink_n = 0;
        ea = 3'b010; eb = 3'b010;
        qa.delete(); qb.delete();
`ifdef SEMAFORO_MON_STATS_EN
        if (ecnt < 255) ecnt++;
`endif
      end else begin
        mst = M_RUN;
        qa.push_back(int'(pla)); qb.push_back(int'(plb));
        if (qa.size() > 8) begin void'(qa.pop_front()); void'(qb.pop_front()); end
        ea = lamp_of(pla); eb = lamp_of(plb);
      end
    end
  endtask

  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic o,
                      input logic c, input logic r);
    LA = a; LB = b; on = o; clr = c; rst = r;
    @(posedge clk);
    if (r) begin
      mst = M_OFF; qa.delete(); qb.delete();
      ea = '0; eb = '0; ef = 1'b0; ec = '0; ecnt = 0;
      pla = G; plb = G; pon = 1'b0; pclr = 1'b0;
    end else begin
      model_process();
      pla = a; plb = b; pon = o; pclr = c;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(G, G, 1'b1, 1'b1, 1'b1);
    checks++;
    if (obs() !== 17'd0) begin
      errors++;
      $display("FAIL reset: got %h expected 00000", obs());
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      step(G, R, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL basic cyc %0d: got %h expected %h", i, obs(), exp_out());
      end
      if (i == 1) begin
        checks++;
        if (lamp_a !== 3'b001 || lamp_b !== 3'b100 || fault !== 1'b0) begin
          errors++;
          $display("FAIL basic_latency: got a=%b b=%b f=%b expected 001 100 0", lamp_a, lamp_b, fault);
        end
      end
    end
  endtask

  task automatic test_legal_seq();
    logic [1:0] sa [10] = '{G, G, G, Y, Y, R, R, R, R, R};
    logic [1:0] sb [10] = '{R, R, R, R, R, R, G, G, G, G};
    int ycycles = 0;
    for (int i = 0; i < 10; i++) begin
      step(sa[i], sb[i], 1'b1, 1'b0, 1'b0);
      if (lamp_a === 3'b010) ycycles++;
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL legal_seq cyc %0d: got %h expected %h", i, obs(), exp_out());
      end
    end
    checks++;
    if (ycycles != 2 || fault !== 1'b0) begin
      errors++;
      $display("FAIL legal_yellow: got %0d yellow cycles fault=%b expected 2 fault=0", ycycles, fault);
    end
  endtask

  task automatic test_early_yellow();
    step(R, R, 1'b0, 1'b0, 1'b0);
    step(R, R, 1'b0, 1'b0, 1'b0);
    step(G, R, 1'b1, 1'b0, 1'b0);
    step(G, R, 1'b1, 1'b0, 1'b0);
    step(Y, R, 1'b1, 1'b0, 1'b0);
    step(R, R, 1'b1, 1'b0, 1'b0);
    step(R, R, 1'b1, 1'b0, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b11 || lamp_a !== 3'b010 || lamp_b !== 3'b010) begin
      errors++;
      $display("FAIL early_yellow: got f=%b code=%b a=%b b=%b expected 1 11 010 010",
               fault, fault_code, lamp_a, lamp_b);
    end
    for (int i = 0; i < 24; i++) begin
      step(G, G, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL blink cyc %0d: got %h expected %h", i, obs(), exp_out());
      end
    end
    step(R, R, 1'b1, 1'b1, 1'b0);
    step(R, R, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs() !== exp_out() || fault !== 1'b0) begin
      errors++;
      $display("FAIL early_clear: got %h expected %h", obs(), exp_out());
    end
  endtask

  task automatic test_conflict();
    step(G, G, 1'b1, 1'b0, 1'b0);
    step(G, G, 1'b1, 1'b0, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b01) begin
      errors++;
      $display("FAIL conflict: got f=%b code=%b expected 1 01", fault, fault_code);
    end
    for (int i = 0; i < 3; i++) step(G, R, 1'b1, 1'b1, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b01 || obs() !== exp_out()) begin
      errors++;
      $display("FAIL clr_nonred: got %h expected %h", obs(), exp_out());
    end
    step(R, R, 1'b1, 1'b1, 1'b0);
    step(R, R, 1'b1, 1'b0, 1'b0);
    checks++;
    if (fault !== 1'b0 || fault_code !== 2'b00 || lamp_a !== 3'b100 || lamp_b !== 3'b100) begin
      errors++;
      $display("FAIL clr_red: got f=%b code=%b a=%b b=%b expected 0 00 100 100",
               fault, fault_code, lamp_a, lamp_b);
    end
  endtask

  task automatic test_priority();
    step(G, X, 1'b1, 1'b0, 1'b0);
    step(G, G, 1'b1, 1'b0, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b10) begin
      errors++;
      $display("FAIL priority: got f=%b code=%b expected 1 10", fault, fault_code);
    end
    for (int i = 0; i < 4; i++) step(R, G, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || obs() !== exp_out()) begin
      errors++;
      $display("FAIL off_in_fault: got %h expected %h", obs(), exp_out());
    end
    step(R, R, 1'b1, 1'b1, 1'b1);
    checks++;
    if (obs() !== 17'd0) begin
      errors++;
      $display("FAIL reset_mid_fault: got %h expected 00000", obs());
    end
  endtask

  task automatic test_stats();
    step(R, R, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(G, R, 1'b1, 1'b0, 1'b0);
      step(G, R, 1'b1, 1'b0, 1'b0);
      step(G, G, 1'b1, 1'b0, 1'b0);
      step(R, R, 1'b1, 1'b1, 1'b0);
      step(R, R, 1'b1, 1'b0, 1'b0);
    end
    step(R, R, 1'b1, 1'b1, 1'b0);
`ifdef SEMAFORO_MON_STATS_EN
    checks++;
    if (fault_cnt !== 8'd3) begin
      errors++;
      $display("FAIL stats_count: got %0d expected 3", fault_cnt);
    end
`endif
    checks++;
    if (obs() !== exp_out()) begin
      errors++;
      $display("FAIL stats_model: got %h expected %h", obs(), exp_out());
    end
    step(R, R, 1'b1, 1'b0, 1'b1);
    checks++;
    if (fault_cnt !== 8'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d expected 0", fault_cnt);
    end
  endtask

  task automatic test_random();
    logic [1:0] a = R, b = R;
    logic       o, c, r;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(9, 0) < 3) a = ($urandom_range(7, 0) == 0) ? X : 2'($urandom_range(2, 0));
      if ($urandom_range(9, 0) < 3) b = ($urandom_range(7, 0) == 0) ? X : 2'($urandom_range(2, 0));
      if ($urandom_range(9, 0) == 0) begin a = R; b = R; end
      o = ($urandom_range(19, 0) != 0);
      c = ($urandom_range(5, 0) == 0);
      r = ($urandom_range(199, 0) == 0);
      step(a, b, o, c, r);
      checks++;
      if (obs() !== exp_out()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h expected %h", i, obs(), exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_legal_seq();
    test_early_yellow();
    test_conflict();
    test_priority();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
